// File: rtl/triumph_lsu.sv
// triumph_lsu: load/store unit between the execute stage and a variable-latency
// data cache port. One request in flight at a time: IDLE accepts, REQ holds the
// memory request until rvalid or timeout, RESP emits a one-cycle response.
module triumph_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [4:0]          req_rd_i,
  output logic                dcache_req_o,
  output logic [ADDR_W-1:0]   dcache_addr_o,
  output logic                dcache_write_en_o,
  output logic [DATA_W/8-1:0] dcache_be_o,
  output logic [DATA_W-1:0]   dcache_wdata_o,
  input  logic                dcache_rvalid_i,
  input  logic [DATA_W-1:0]   dcache_rdata_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [4:0]          rsp_rd_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // Latched request fields
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [LANE_W-1:0]   r_lane;
  logic [4:0]          r_rd;

  // Memory-side registers, stable for the whole REQ state
  logic [ADDR_W-1:0]   r_dc_addr;
  logic                r_dc_we;
  logic [BE_W-1:0]     r_dc_be;
  logic [DATA_W-1:0]   r_dc_wdata;

  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [LANE_W-1:0]   w_lane;
  logic                w_misaligned;
  logic [BE_W-1:0]     w_be_base;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [ADDR_W-1:0]   w_dc_addr;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_mask;
  logic                w_sign;
  logic [DATA_W-1:0]   w_ext;
  logic                w_timeout;

  assign w_lane     = req_addr_i[LANE_W-1:0];
  assign w_be       = w_be_base << w_lane;
  assign w_wdata_sh = req_wdata_i << {w_lane, 3'b000};
  assign w_dc_addr  = {req_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Request-side decode: alignment check and unshifted byte-enable pattern
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_misaligned = 1'b0;
    w_be_base    = '0;
    case (req_size_i)
      2'd0: begin
        w_be_base = BE_W'(1);
      end
      2'd1: begin
        w_be_base    = BE_W'(2'b11);
        w_misaligned = req_addr_i[0];
      end
      2'd2: begin
        w_be_base    = BE_W'(4'hF);
        w_misaligned = (req_addr_i[1:0] != 2'b00);
      end
      default: begin
        w_be_base    = '1;
        w_misaligned = (DATA_W == 32) || (req_addr_i[2:0] != 3'b000);
      end
    endcase
  end

  // Load-side alignment: shift the addressed lane down, then sign/zero extend
  always_comb begin
    w_shift = dcache_rdata_i >> {r_lane, 3'b000};
    w_mask  = '1;
    w_sign  = w_shift[DATA_W-1];
    case (r_size)
      2'd0: begin
        w_mask = DATA_W'(8'hFF);
        w_sign = w_shift[7];
      end
      2'd1: begin
        w_mask = DATA_W'(16'hFFFF);
        w_sign = w_shift[15];
      end
      2'd2: begin
        w_mask = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_shift[31];
      end
      default: ;
    endcase
    w_ext = (w_shift & w_mask) | ({DATA_W{w_sign & ~r_unsigned}} & ~w_mask);
  end

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_next = w_misaligned ? S_RESP : S_REQ;
      S_REQ:  if (dcache_rvalid_i || w_timeout) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from state; response fields are zero outside RESP
  always_comb begin
    req_ready_o       = (r_state == S_IDLE);
    busy_o            = (r_state != S_IDLE);
    dcache_req_o      = (r_state == S_REQ);
    rsp_valid_o       = (r_state == S_RESP);
    rsp_rdata_o       = (r_state == S_RESP) ? r_rsp_rdata : '0;
    rsp_rd_o          = (r_state == S_RESP) ? r_rd : 5'd0;
    rsp_err_o         = (r_state == S_RESP) && r_rsp_err;
    dcache_addr_o     = r_dc_addr;
    dcache_write_en_o = r_dc_we;
    dcache_be_o       = r_dc_be;
    dcache_wdata_o    = r_dc_wdata;
  end

  // Datapath: latch request, drive memory registers, count REQ cycles, capture response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_lane      <= '0;
      r_rd        <= 5'd0;
      r_dc_addr   <= '0;
      r_dc_we     <= 1'b0;
      r_dc_be     <= '0;
      r_dc_wdata  <= '0;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we       <= req_we_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_lane     <= w_lane;
            r_rd       <= req_rd_i;
            r_cnt      <= '0;
            if (w_misaligned) begin
              // No memory access: answer straight away with an error
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_dc_addr  <= w_dc_addr;
              r_dc_we    <= req_we_i;
              r_dc_be    <= w_be;
              r_dc_wdata <= w_wdata_sh;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // rvalid takes priority over a timeout in the same cycle
          if (dcache_rvalid_i) begin
            r_rsp_rdata <= r_we ? '0 : w_ext;
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triumph_lsu.sv
// Directed bench for triumph_lsu: a 32-bit instance and a 64-bit instance,
// both with TIMEOUT=4, sharing clock, reset and request control fields.
module tb_triumph_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, uns;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [4:0]  rd;

  // 32-bit instance
  logic        a_valid, a_ready, a_dreq, a_dwe, a_rvalid, a_rspv, a_err, a_busy;
  logic [31:0] a_wdata, a_daddr, a_dwdata, a_rdata, a_rsp_rdata;
  logic [3:0]  a_be;
  logic [4:0]  a_rsp_rd;

  // 64-bit instance
  logic        b_valid, b_ready, b_dreq, b_dwe, b_rvalid, b_rspv, b_err, b_busy;
  logic [63:0] b_wdata, b_dwdata, b_rdata, b_rsp_rdata;
  logic [31:0] b_daddr;
  logic [7:0]  b_be;
  logic [4:0]  b_rsp_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  triumph_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(we), .req_size_i(size),
    .req_unsigned_i(uns), .req_addr_i(addr), .req_wdata_i(a_wdata), .req_rd_i(rd),
    .dcache_req_o(a_dreq), .dcache_addr_o(a_daddr), .dcache_write_en_o(a_dwe),
    .dcache_be_o(a_be), .dcache_wdata_o(a_dwdata), .dcache_rvalid_i(a_rvalid),
    .dcache_rdata_i(a_rdata), .rsp_valid_o(a_rspv), .rsp_rdata_o(a_rsp_rdata),
    .rsp_rd_o(a_rsp_rd), .rsp_err_o(a_err), .busy_o(a_busy)
  );

  triumph_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(we), .req_size_i(size),
    .req_unsigned_i(uns), .req_addr_i(addr), .req_wdata_i(b_wdata), .req_rd_i(rd),
    .dcache_req_o(b_dreq), .dcache_addr_o(b_daddr), .dcache_write_en_o(b_dwe),
    .dcache_be_o(b_be), .dcache_wdata_o(b_dwdata), .dcache_rvalid_i(b_rvalid),
    .dcache_rdata_i(b_rdata), .rsp_valid_o(b_rspv), .rsp_rdata_o(b_rsp_rdata),
    .rsp_rd_o(b_rsp_rd), .rsp_err_o(b_err), .busy_o(b_busy)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on the shared fields
  task automatic set_req(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] ad, input logic [4:0] r);
    we = w; size = s; uns = u; addr = ad; rd = r;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_rvalid = 1'b0; b_rvalid = 1'b0;
    a_wdata = '0; b_wdata = '0; a_rdata = '0; b_rdata = '0;
    set_req(1'b0, 2'd0, 1'b0, 32'h0, 5'd0);
    step(); step();

    // Reset state
    check("rst_ready", a_ready, 1);
    check("rst_dreq", a_dreq, 0);
    check("rst_rspv", a_rspv, 0);
    check("rst_busy", a_busy, 0);
    check("rst_be", a_be, 0);
    check("rst_addr", a_daddr, 0);
    check("rst_b_ready", b_ready, 1);
    rst = 1'b0;
    step();

    // Store byte 0xA5 to 0x103
    set_req(1'b1, 2'd0, 1'b0, 32'h0000_0103, 5'd5);
    a_wdata = 32'h0000_00A5; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("sb_dreq", a_dreq, 1);
    check("sb_be", a_be, 4'b1000);
    check("sb_wdata", a_dwdata[31:24], 8'hA5);
    check("sb_we", a_dwe, 1);
    check("sb_addr", a_daddr, 32'h0000_0100);
    check("sb_ready", a_ready, 0);
    step();
    check("sb_hold", a_dreq, 1);
    a_rvalid = 1'b1;
    step();
    a_rvalid = 1'b0;
    check("sb_rspv", a_rspv, 1);
    check("sb_err", a_err, 0);
    check("sb_rdata", a_rsp_rdata, 0);
    check("sb_rd", a_rsp_rd, 5'd5);
    check("sb_dreq_off", a_dreq, 0);
    step();
    check("sb_rsp_pulse", a_rspv, 0);
    check("sb_ready_back", a_ready, 1);

    // Load half signed at 0x102, 1-cycle latency
    set_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 5'd7);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("lh_be", a_be, 4'b1100);
    check("lh_we", a_dwe, 0);
    a_rvalid = 1'b1; a_rdata = 32'h8001_1234;
    step();
    a_rvalid = 1'b0;
    check("lh_rspv", a_rspv, 1);
    check("lh_rdata", a_rsp_rdata, 32'hFFFF_8001);
    check("lh_rd", a_rsp_rd, 5'd7);
    step();

    // Same load, unsigned
    set_req(1'b0, 2'd1, 1'b1, 32'h0000_0102, 5'd7);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    a_rvalid = 1'b1;
    step();
    a_rvalid = 1'b0;
    check("lhu_rdata", a_rsp_rdata, 32'h0000_8001);
    step();

    // Load byte signed at 0x101
    set_req(1'b0, 2'd0, 1'b0, 32'h0000_0101, 5'd9);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("lb_be", a_be, 4'b0010);
    a_rvalid = 1'b1; a_rdata = 32'h1234_80FF;
    step();
    a_rvalid = 1'b0;
    check("lb_rdata", a_rsp_rdata, 32'hFFFF_FF80);
    step();

    // Misaligned word load at 0x101
    set_req(1'b0, 2'd2, 1'b0, 32'h0000_0101, 5'd3);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("mis_rspv", a_rspv, 1);
    check("mis_err", a_err, 1);
    check("mis_rdata", a_rsp_rdata, 0);
    check("mis_rd", a_rsp_rd, 5'd3);
    check("mis_dreq", a_dreq, 0);
    step();
    check("mis_dreq2", a_dreq, 0);
    check("mis_ready", a_ready, 1);

    // Size 3 on the 32-bit unit
    set_req(1'b0, 2'd3, 1'b0, 32'h0000_0000, 5'd1);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("d32_err", a_err, 1);
    check("d32_dreq", a_dreq, 0);
    step();

    // Timeout: no rvalid, request held exactly 4 cycles
    set_req(1'b0, 2'd2, 1'b0, 32'h0000_0040, 5'd4);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_dreq%0d", i), a_dreq, 1);
      step();
    end
    check("to_dreq_off", a_dreq, 0);
    check("to_rspv", a_rspv, 1);
    check("to_err", a_err, 1);
    check("to_rdata", a_rsp_rdata, 0);
    step();

    // rvalid in the 4th REQ cycle wins over the timeout
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tw_dreq%0d", i), a_dreq, 1);
      if (i == 3) begin
        a_rvalid = 1'b1; a_rdata = 32'h1122_3344;
      end
      step();
      a_rvalid = 1'b0;
    end
    check("tw_rspv", a_rspv, 1);
    check("tw_err", a_err, 0);
    check("tw_rdata", a_rsp_rdata, 32'h1122_3344);
    step();

    // 64-bit: dword load at 0x8
    set_req(1'b0, 2'd3, 1'b0, 32'h0000_0008, 5'd12);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("b_dw_be", b_be, 8'hFF);
    check("b_dw_addr", b_daddr, 32'h0000_0008);
    b_rvalid = 1'b1; b_rdata = 64'h8877_6655_4433_2211;
    step();
    b_rvalid = 1'b0;
    check("b_dw_rspv", b_rspv, 1);
    check("b_dw_err", b_err, 0);
    check("b_dw_rdata", b_rsp_rdata, 64'h8877_6655_4433_2211);
    check("b_dw_rd", b_rsp_rd, 5'd12);
    step();

    // 64-bit: misaligned dword at 0x4
    set_req(1'b0, 2'd3, 1'b0, 32'h0000_0004, 5'd13);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("b_dwmis_err", b_err, 1);
    check("b_dwmis_dreq", b_dreq, 0);
    step();

    // 64-bit: signed word load from upper half at 0x4
    set_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 5'd14);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("b_lw_be", b_be, 8'hF0);
    check("b_lw_addr", b_daddr, 32'h0000_0000);
    b_rvalid = 1'b1; b_rdata = 64'h8000_0001_0000_0000;
    step();
    b_rvalid = 1'b0;
    check("b_lw_rdata", b_rsp_rdata, 64'hFFFF_FFFF_8000_0001);
    step();

    // Reset in the middle of REQ abandons the transaction
    set_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 5'd6);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("rr_dreq", a_dreq, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_dreq_off", a_dreq, 0);
    check("rr_ready", a_ready, 1);
    check("rr_busy", a_busy, 0);
    check("rr_rspv", a_rspv, 0);
    a_rvalid = 1'b1; a_rdata = 32'hCAFE_F00D;
    step();
    a_rvalid = 1'b0;
    check("rr_late_rspv", a_rspv, 0);
    check("rr_late_busy", a_busy, 0);
    step();
    check("rr_late_rspv2", a_rspv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
